decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage; successor to the combinational decoder.
- Holds one instruction from fetch with a valid/ready handshake and presents decoded control fields to execute.
- Inserts bubbles for load-use hazards and for HI/LO reads behind an in-flight multi-cycle MULT/DIV; latencies are parametrised.

Parameters:
- MUL_CYCLES, 4: cycles HI/LO stay busy after MULT/MULTU issues (>=1).
- DIV_CYCLES, 32: cycles HI/LO stay busy after DIV/DIVU issues (>=1).
- HAZARD_EN, 1: 1 enables load-use bubble; 0 disables it (forwarding-only pipeline).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inValid  in  1  fetch offers an instruction.
- inReady  out  1  stage accepts this cycle.
- inIns  in  32  instruction word.
- inPc  in  32  instruction address.
- flush  in  1  discard held instruction (branch/exception).
- exLoad  in  1  instruction now in EX is a load.
- exRt  in  5  destination register of that load.
- outValid  out  1  decoded instruction offered to EX.
- outReady  in  1  EX accepts.
- outIns  out  32  held instruction.
- outPc  out  32  held PC.
- outWriteReg  out  1  instruction writes GPR.
- outDest  out  5  destination: rd for op 0, 31 for JAL, rt otherwise.
- outReadMem  out  1  load (op 0x20-0x26).
- outWriteMem  out  1  store (op 0x28,0x29,0x2A,0x2B,0x2E).
- outJmp  out  1  J, JAL, JR, JALR.
- outBranch  out  1  op 1,4,5,6,7.
- outMdOp  out  1  op 0 with func 0x18-0x1B.
- mdBusy  out  1  HI/LO busy counter nonzero.

Behaviour:
- Reset (async, rst_n low): entry empty, outValid=0, mdCnt=0, mdBusy=0, outIns/outPc=0, all decoded fields 0. inReady=0 while rst_n is low.
- Decoded fields are registered at capture and are a pure function of the held word. They are 0 when the entry is empty.
- Register usage for hazards:
  - rsUsed = not (J, JAL, LUI, SLL/SRL/SRA).
  - rtUsed = op 0, BEQ, BNE, or any store.
  - rs or rt equal to 0 never causes a hazard.
- loadUse = HAZARD_EN & exLoad & exRt!=0 & ((rsUsed & rs==exRt) | (rtUsed & rt==exRt)).
- hiloWait = mdBusy & (held op 0 with func 0x10, 0x12, or 0x18-0x1B).
- stall = full & (loadUse | hiloWait).
- outValid = full & ~stall. A stall is a bubble: the entry is held and outValid is 0.
- fire_out = outValid & outReady.
- inReady = ~full | fire_out. Capture on inValid & inReady. Entry latency is 1 cycle from capture to outValid.
- Simultaneous fire_out and capture: the new word replaces the old word with no empty cycle.
- flush:
  - Empties the entry next cycle and overrides any same-cycle capture; inReady is 0 during flush.
  - Does not clear mdCnt, because the multiplier is already running.
- mdCnt:
  - Loaded on fire_out of outMdOp: MUL_CYCLES for func 0x18/0x19, DIV_CYCLES for 0x1A/0x1B.
  - Otherwise decrements to 0 and saturates at 0.
  - mdBusy = mdCnt!=0.
  - A back-to-back MD op waits until mdCnt reaches 0, then reloads.
- Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- Backpressure: while outValid=1 and outReady=0, outIns, outPc and all fields hold stable.

Test Plan:
- Reset then inValid=1 with ADDU $3,$1,$2 (0x00221821) -> outValid=1 next cycle, outWriteReg=1, outDest=3, inReady stays 1 with outReady=1.
- LW in EX (exLoad=1, exRt=5) with held ADD $6,$5,$7 -> outValid=0 for each cycle exLoad persists; emits once exLoad=0. With HAZARD_EN=0 -> no bubble.
- DIV (func 0x1A) fires, then MFLO held -> outValid=0 for exactly DIV_CYCLES=32 cycles, mdBusy falls, then MFLO emits.
- outReady=0 for 3 cycles with JAL held -> outDest=31, outJmp=1, fields stable, inReady=0; on release the next word is captured in the same cycle.
- flush with inValid=1 in the same cycle -> entry empty next cycle, outValid=0, mdCnt unaffected.
- Assert rst_n=0 mid-DIV -> outValid, mdBusy and mdCnt are 0 immediately (asynchronously).

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The stage itself uses the slave modport.
interface decode_stage_if;
   logic        inValid;
   logic        inReady;
   logic [31:0] inIns;
   logic [31:0] inPc;
   logic        flush;
   logic        exLoad;
   logic [4:0]  exRt;
   logic        outValid;
   logic        outReady;
   logic [31:0] outIns;
   logic [31:0] outPc;
   logic        outWriteReg;
   logic [4:0]  outDest;
   logic        outReadMem;
   logic        outWriteMem;
   logic        outJmp;
   logic        outBranch;
   logic        outMdOp;
   logic        mdBusy;

   modport master (
      output inValid, inIns, inPc, flush, exLoad, exRt, outReady,
      input  inReady, outValid, outIns, outPc, outWriteReg, outDest,
             outReadMem, outWriteMem, outJmp, outBranch, outMdOp, mdBusy
   );

   modport slave (
      input  inValid, inIns, inPc, flush, exLoad, exRt, outReady,
      output inReady, outValid, outIns, outPc, outWriteReg, outDest,
             outReadMem, outWriteMem, outJmp, outBranch, outMdOp, mdBusy
   );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS decode stage: single-entry holding register with valid/ready,
// load-use and HI/LO-busy bubbles, and a down-counter tracking MULT/DIV latency.
module decode_stage #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter bit HAZARD_EN  = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   decode_stage_if.slave bus
);
   localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW     = $clog2(MD_MAX + 1);

   typedef struct packed {
      logic       write_reg;
      logic [4:0] dest;
      logic       read_mem;
      logic       write_mem;
      logic       jmp;
      logic       branch;
      logic       md_op;
   } fields_t;

   function automatic fields_t decode(input logic [31:0] ins);
      fields_t    f;
      logic [5:0] op;
      logic [5:0] func;
      logic       r_type;
      op          = ins[31:26];
      func        = ins[5:0];
      r_type      = (op == 6'd0);
      f.md_op     = r_type && (func inside {[6'h18:6'h1B]});
      f.jmp       = (op == 6'd2) || (op == 6'd3) || (r_type && (func == 6'h08 || func == 6'h09));
      f.branch    = op inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7};
      f.read_mem  = op inside {[6'h20:6'h26]};
      f.write_mem = op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
      f.dest      = r_type ? ins[15:11] : ((op == 6'd3) ? 5'd31 : ins[20:16]);
      // R-type writes rd except jumps-without-link, traps, HI/LO writes and MD ops
      f.write_reg = r_type ? !(func inside {6'h08, 6'h0C, 6'h0D, 6'h11, 6'h13, [6'h18:6'h1B]})
                           : ((op == 6'd3) || f.read_mem || (op inside {[6'h08:6'h0F]}));
      return f;
   endfunction

   logic          full_q, full_d;
   logic [31:0]   ins_q, ins_d;
   logic [31:0]   pc_q, pc_d;
   fields_t       fld_q, fld_d;
   logic [CW-1:0] md_cnt_q, md_cnt_d;

   logic [5:0] op_h, func_h;
   logic [4:0] rs_h, rt_h;
   logic       rs_used, rt_used, load_use, hilo_wait, stall;
   logic       md_busy, out_valid, fire_out, in_ready, capture;

   always_comb begin
      op_h      = ins_q[31:26];
      func_h    = ins_q[5:0];
      rs_h      = ins_q[25:21];
      rt_h      = ins_q[20:16];
      rs_used   = !((op_h == 6'd2) || (op_h == 6'd3) || (op_h == 6'h0F) ||
                    ((op_h == 6'd0) && (func_h inside {6'h00, 6'h02, 6'h03})));
      rt_used   = (op_h == 6'd0) || (op_h == 6'd4) || (op_h == 6'd5) || fld_q.write_mem;
      // exRt != 0 already excludes a match on register 0
      load_use  = HAZARD_EN && bus.exLoad && (bus.exRt != 5'd0) &&
                  ((rs_used && (rs_h == bus.exRt)) || (rt_used && (rt_h == bus.exRt)));
      md_busy   = (md_cnt_q != '0);
      hilo_wait = md_busy && (op_h == 6'd0) &&
                  ((func_h == 6'h10) || (func_h == 6'h12) || (func_h inside {[6'h18:6'h1B]}));
      stall     = full_q && (load_use || hilo_wait);
      out_valid = full_q && !stall;
      fire_out  = out_valid && bus.outReady;
      in_ready  = rst_n && !bus.flush && (!full_q || fire_out);
      capture   = bus.inValid && in_ready;
   end

   always_comb begin
      full_d = full_q;
      ins_d  = ins_q;
      pc_d   = pc_q;
      fld_d  = fld_q;
      if (bus.flush || (fire_out && !capture)) begin
         full_d = 1'b0;
         ins_d  = '0;
         pc_d   = '0;
         fld_d  = '0;
      end else if (capture) begin
         full_d = 1'b1;
         ins_d  = bus.inIns;
         pc_d   = bus.inPc;
         fld_d  = decode(bus.inIns);
      end
   end

   // flush deliberately leaves the counter alone: the multiplier is already running
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (fire_out && fld_q.md_op)
         md_cnt_d = func_h[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      else if (md_busy)
         md_cnt_d = md_cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q   <= 1'b0;
         ins_q    <= '0;
         pc_q     <= '0;
         fld_q    <= '0;
         md_cnt_q <= '0;
      end else begin
         full_q   <= full_d;
         ins_q    <= ins_d;
         pc_q     <= pc_d;
         fld_q    <= fld_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   assign bus.inReady     = in_ready;
   assign bus.outValid    = out_valid;
   assign bus.outIns      = ins_q;
   assign bus.outPc       = pc_q;
   assign bus.outWriteReg = fld_q.write_reg;
   assign bus.outDest     = fld_q.dest;
   assign bus.outReadMem  = fld_q.read_mem;
   assign bus.outWriteMem = fld_q.write_mem;
   assign bus.outJmp      = fld_q.jmp;
   assign bus.outBranch   = fld_q.branch;
   assign bus.outMdOp     = fld_q.md_op;
   assign bus.mdBusy      = md_busy;
endmodule
